// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared types and encodings for the multicycle RV32I controller
package controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_ILLEGAL
    } state_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - controller to datapath control/status bundle
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, zero,
        output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, instr_done, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, instr_done, illegal
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// rtl/multicycle_controller_alu_decoder.sv - maps alu_op and funct fields to an ALU operation
module alu_decoder
    import controller_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_ADD;
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type from addi, whose imm bit 30 must not select sub
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM sequencing a multicycle RV32I datapath
module multicycle_controller
    import controller_pkg::*;
#(
    parameter bit TRAP_ILLEGAL = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    state_t     state, state_next;
    alu_op_t    alu_op;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic       instr_done, illegal, branch_taken;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = S_EXECUTEI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    default:           state_next = TRAP_ILLEGAL ? S_ILLEGAL : S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = S_FETCH;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_ILLEGAL:  state_next = S_ILLEGAL;
            default:    state_next = S_FETCH;
        endcase
    end

    assign branch_taken = ((bus.funct3 == 3'b000) &  bus.zero) |
                          ((bus.funct3 == 3'b001) & ~bus.zero);

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = ALU_OP_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                // an unknown opcode retires here when it is not trapped
                if (!TRAP_ILLEGAL) begin
                    case (bus.op)
                        OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: instr_done = 1'b0;
                        default: instr_done = 1'b1;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = ALU_OP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_op     = ALU_OP_SUB;
                instr_done = 1'b1;
                pc_write   = branch_taken;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_ILLEGAL: illegal = 1'b1;
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .op5         (bus.op[5]),
        .funct7b5    (bus.funct7b5),
        .alu_control (alu_control)
    );

    assign bus.pc_write    = pc_write;
    assign bus.adr_src     = adr_src;
    assign bus.mem_write   = mem_write;
    assign bus.ir_write    = ir_write;
    assign bus.reg_write   = reg_write;
    assign bus.result_src  = result_src;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.imm_src     = imm_src_of(bus.op);
    assign bus.alu_control = alu_control;
    assign bus.instr_done  = instr_done;
    assign bus.illegal     = illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

    typedef struct {
        string       name;
        logic [19:0] exp;
    } sb_item_t;

    logic clk;
    logic reset;
    logic probe;
    int   n_cmp;
    int   n_bad;
    sb_item_t sb_q[$];

    multicycle_controller_if bus();

    multicycle_controller #(.TRAP_ILLEGAL(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b, imm_src, alu_control, instr_done, illegal}
    function automatic logic [19:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] ac, input logic done, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, 2'b00, ac, done, ill};
    endfunction

    function automatic logic [19:0] actual();
        return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
                bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src,
                bus.alu_control, bus.instr_done, bus.illegal};
    endfunction

    logic [19:0] e_fetch, e_decode, e_memadr, e_memread, e_memwb, e_memwrite;
    logic [19:0] e_aluwb, e_jal, e_illegal;

    initial begin
        e_fetch    = mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
        e_decode   = mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0);
        e_memadr   = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0);
        e_memread  = mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
        e_memwb    = mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0);
        e_memwrite = mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
        e_aluwb    = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
        e_jal      = mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0);
        e_illegal  = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1);
    end

    always @(negedge clk or posedge probe) begin
        if (sb_q.size() != 0) begin
            sb_item_t it;
            logic [19:0] act;
            it  = sb_q.pop_front();
            act = actual();
            n_cmp++;
            if (act !== it.exp) begin
                n_bad++;
                $display("FAIL %s: got %b required %b", it.name, act, it.exp);
            end
        end
    end

    task automatic push(input string name, input logic [1:0] imm, input logic [19:0] e);
        sb_item_t it;
        logic [19:0] v;
        v      = e;
        v[6:5] = imm;
        it.name = name;
        it.exp  = v;
        sb_q.push_back(it);
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        bus.op       = o;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.zero     = z;
    endtask

    task automatic cyc(input string name, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input logic [1:0] imm, input logic [19:0] e);
        drive(o, f3, f7, z);
        push(name, imm, e);
        @(posedge clk);
        #1;
    endtask

    task automatic rtype(input string name, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [2:0] ac);
        logic [19:0] ex;
        ex = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, (o == 7'b0010011) ? 2'b01 : 2'b00, ac, 0, 0);
        cyc({name, "_fetch"},  o, f3, f7, 0, 2'b00, e_fetch);
        cyc({name, "_decode"}, o, f3, f7, 0, 2'b00, e_decode);
        cyc({name, "_exec"},   o, f3, f7, 0, 2'b00, ex);
        cyc({name, "_aluwb"},  o, f3, f7, 0, 2'b00, e_aluwb);
    endtask

    task automatic branch(input string name, input logic [2:0] f3, input logic z, input logic pcw);
        cyc({name, "_fetch"},  7'b1100011, f3, 0, z, 2'b10, e_fetch);
        cyc({name, "_decode"}, 7'b1100011, f3, 0, z, 2'b10, e_decode);
        cyc({name, "_branch"}, 7'b1100011, f3, 0, z, 2'b10,
            mk(pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 1, 0));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        probe = 1'b0;
        reset = 1'b0;
        drive(7'b0000011, 3'b010, 0, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cyc("reset_hold", 7'b0000011, 3'b010, 0, 0, 2'b00, e_fetch);
        reset = 1'b1;

        cyc("lw_fetch",   7'b0000011, 3'b010, 0, 0, 2'b00, e_fetch);
        cyc("lw_decode",  7'b0000011, 3'b010, 0, 0, 2'b00, e_decode);
        cyc("lw_memadr",  7'b0000011, 3'b010, 0, 0, 2'b00, e_memadr);
        cyc("lw_memread", 7'b0000011, 3'b010, 0, 0, 2'b00, e_memread);
        cyc("lw_memwb",   7'b0000011, 3'b010, 0, 0, 2'b00, e_memwb);

        cyc("sw_fetch",    7'b0100011, 3'b010, 0, 0, 2'b01, e_fetch);
        cyc("sw_decode",   7'b0100011, 3'b010, 0, 0, 2'b01, e_decode);
        cyc("sw_memadr",   7'b0100011, 3'b010, 0, 0, 2'b01, e_memadr);
        cyc("sw_memwrite", 7'b0100011, 3'b010, 0, 0, 2'b01, e_memwrite);

        rtype("r_sub",  7'b0110011, 3'b000, 1, 3'b001);
        rtype("r_add",  7'b0110011, 3'b000, 0, 3'b000);
        rtype("r_slt",  7'b0110011, 3'b010, 0, 3'b101);
        rtype("r_or",   7'b0110011, 3'b110, 0, 3'b011);
        rtype("r_and",  7'b0110011, 3'b111, 0, 3'b010);
        rtype("i_addi", 7'b0010011, 3'b000, 1, 3'b000);
        rtype("i_andi", 7'b0010011, 3'b111, 0, 3'b010);

        branch("beq_taken",  3'b000, 1, 1);
        branch("beq_not",    3'b000, 0, 0);
        branch("bne_taken",  3'b001, 0, 1);
        branch("bne_not",    3'b001, 1, 0);
        branch("f3_100",     3'b100, 1, 0);

        cyc("jal_fetch",  7'b1101111, 3'b000, 0, 0, 2'b11, e_fetch);
        cyc("jal_decode", 7'b1101111, 3'b000, 0, 0, 2'b11, e_decode);
        cyc("jal_jal",    7'b1101111, 3'b000, 0, 0, 2'b11, e_jal);
        cyc("jal_aluwb",  7'b1101111, 3'b000, 0, 0, 2'b11, e_aluwb);

        cyc("sw2_fetch",  7'b0100011, 3'b010, 0, 0, 2'b01, e_fetch);
        cyc("sw2_decode", 7'b0100011, 3'b010, 0, 0, 2'b01, e_decode);
        cyc("sw2_memadr", 7'b0100011, 3'b010, 0, 0, 2'b01, e_memadr);
        drive(7'b0100011, 3'b010, 0, 0);
        push("sw2_memwrite", 2'b01, e_memwrite);
        @(negedge clk);
        #2;
        reset = 1'b0;
        push("async_reset_memwrite", 2'b01, e_fetch);
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset_after_sw", 7'b0100011, 3'b010, 0, 0, 2'b01, e_fetch);
        reset = 1'b1;
        cyc("post_reset_fetch", 7'b1111111, 3'b000, 0, 0, 2'b00, e_fetch);
        cyc("ill_decode",       7'b1111111, 3'b000, 0, 0, 2'b00, e_decode);
        for (int i = 0; i < 10; i++) cyc("ill_hold", 7'b1111111, 3'b000, 0, i[0], 2'b00, e_illegal);
        reset = 1'b0;
        cyc("ill_reset", 7'b0000011, 3'b010, 0, 0, 2'b00, e_fetch);
        reset = 1'b1;
        cyc("ill_exit_fetch",  7'b0000011, 3'b010, 0, 0, 2'b00, e_fetch);
        cyc("ill_exit_decode", 7'b0000011, 3'b010, 0, 0, 2'b00, e_decode);

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
